// File: rtl/local_ni_pkg.sv
// Shared definitions for the local-port network interface.
//   - flit field positions: [2:0] dst, [5:3] src, [DW-1:6] payload
//   - injection FSM state type
//   - saturating increment used by the statistics counters
package local_ni_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int FLIT_DST_LSB = 0;
    localparam int FLIT_DST_MSB = 2;
    localparam int FLIT_SRC_LSB = 3;
    localparam int FLIT_SRC_MSB = 5;
    localparam int FLIT_PL_LSB  = 6;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_STALL = 2'd2
    } tx_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request and data
//   pop        : consume head (ignored when empty)
//   rdata      : current head, valid whenever !empty
//   full/empty : status derived from the registered occupancy
//   count      : number of stored entries
// A push while full is accepted only if a pop happens in the same cycle;
// callers that must not use that slot gate push with !full themselves.
module ni_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;

    // Head is read straight from the array so it is visible the cycle
    // after it was written (fall-through behaviour).
    assign rdata = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/local_ni.sv
// Network interface for a router LOCAL port.
//   Core TX side : tx_valid/tx_ready/tx_dst/tx_payload, tx_err pulse on self-addressed packets
//   Router side  : net_data_out/net_valid_out (injection, obeys net_full_in),
//                  net_data_in/net_valid_in (ejection, always accepted or dropped)
//   Core RX side : rx_valid/rx_ready/rx_src/rx_payload (FWFT head), rx_overflow sticky
//   Statistics   : tx_count, rx_count, drop_count (saturating), cleared by clr_stats
module local_ni
    import local_ni_pkg::*;
#(
    parameter logic [2:0] NODE_ADDR = 3'd0,
    parameter int         TX_DEPTH  = 4,
    parameter int         RX_DEPTH  = 8,
    parameter int         DW        = DATA_WIDTH,
    localparam int        PW        = DW - 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [2:0]       tx_dst,
    input  logic [PW-1:0]    tx_payload,
    output logic             tx_err,
    output logic [DW-1:0]    net_data_out,
    output logic             net_valid_out,
    input  logic             net_full_in,
    input  logic [DW-1:0]    net_data_in,
    input  logic             net_valid_in,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [2:0]       rx_src,
    output logic [PW-1:0]    rx_payload,
    output logic             rx_overflow,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    // ---------------- TX path ----------------
    logic             tx_full;
    logic             tx_empty;
    logic [TX_CW-1:0] tx_fifo_cnt;
    logic             tx_accept;
    logic             tx_push;
    logic             tx_pop;
    logic [DW-1:0]    tx_flit;
    logic             tx_err_reg;
    tx_state_t        state_reg;
    tx_state_t        state_next;

    // tx_ready uses only the registered full flag, so a pop in the same
    // cycle never lets an extra packet in.
    assign tx_ready  = !tx_full;
    assign tx_accept = tx_valid && tx_ready;
    assign tx_push   = tx_accept && (tx_dst != NODE_ADDR);
    assign tx_flit   = {tx_payload, NODE_ADDR, tx_dst};

    ni_fifo #(.WIDTH(DW), .DEPTH(TX_DEPTH)) tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_flit),
        .rdata (net_data_out),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= TX_IDLE;
            tx_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tx_err_reg <= tx_accept && (tx_dst == NODE_ADDR);
        end
    end

    assign tx_err = tx_err_reg;

    always_comb begin
        state_next    = state_reg;
        net_valid_out = 1'b0;
        tx_pop        = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                // Leaving on the push itself gives valid one cycle after accept.
                if (tx_push || !tx_empty) state_next = TX_SEND;
            end
            TX_SEND: begin
                net_valid_out = !net_full_in && !tx_empty;
                tx_pop        = net_valid_out;
                if (net_full_in) begin
                    state_next = TX_STALL;
                end else if (tx_pop && (tx_fifo_cnt == TX_CW'(1)) && !tx_push) begin
                    state_next = TX_IDLE;
                end
            end
            TX_STALL: begin
                if (!net_full_in) state_next = TX_SEND;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // ---------------- RX path ----------------
    logic             rx_full;
    logic             rx_empty;
    logic [RX_CW-1:0] rx_fifo_cnt;
    logic [DW-1:0]    rx_head;
    logic             rx_pop;
    logic             rx_push;
    logic             rx_drop;
    logic             rx_overflow_reg;

    assign rx_pop   = rx_valid && rx_ready;
    // The router cannot be back-pressured: each arriving flit is either
    // stored or counted as a drop in the cycle it arrives.
    assign rx_push  = net_valid_in && (net_data_in[FLIT_DST_MSB:FLIT_DST_LSB] == NODE_ADDR)
                      && (!rx_full || rx_pop);
    assign rx_drop  = net_valid_in && !rx_push;

    ni_fifo #(.WIDTH(DW), .DEPTH(RX_DEPTH)) rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (net_data_in),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_fifo_cnt)
    );

    assign rx_valid   = !rx_empty;
    assign rx_src     = rx_head[FLIT_SRC_MSB:FLIT_SRC_LSB];
    assign rx_payload = rx_head[DW-1:FLIT_PL_LSB];

    logic unused_ok;
    assign unused_ok = &{1'b0, rx_fifo_cnt, rx_head[FLIT_DST_MSB:FLIT_DST_LSB]};

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            rx_overflow_reg <= 1'b0;
        end else if (rx_drop) begin
            rx_overflow_reg <= 1'b1;
        end
    end

    assign rx_overflow = rx_overflow_reg;

    // ---------------- statistics ----------------
    // Index 0: injected flits, 1: flits stored in RX, 2: RX drops.
    logic [2:0] stat_inc;
    assign stat_inc = {rx_drop, rx_push, tx_pop};

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : stat_g
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst || clr_stats) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi]) begin
                cnt_reg <= sat_inc(cnt_reg);
            end
        end
    end

    assign tx_count   = stat_g[0].cnt_reg;
    assign rx_count   = stat_g[1].cnt_reg;
    assign drop_count = stat_g[2].cnt_reg;

endmodule

// File: tb/tb_local_ni.sv
// Testbench for local_ni (NODE_ADDR=3, TX_DEPTH=4, RX_DEPTH=8, DW=32).
// Directed scenarios plus a randomized phase, all checked against a
// queue-based reference model of the interface.
module tb_local_ni;

    localparam int         DW = 32;
    localparam int         PW = DW - 6;
    localparam logic [2:0] ME = 3'd3;

    logic          clk;
    logic          rst;
    logic          tx_valid;
    logic          tx_ready;
    logic [2:0]    tx_dst;
    logic [PW-1:0] tx_payload;
    logic          tx_err;
    logic [DW-1:0] net_data_out;
    logic          net_valid_out;
    logic          net_full_in;
    logic [DW-1:0] net_data_in;
    logic          net_valid_in;
    logic          rx_valid;
    logic          rx_ready;
    logic [2:0]    rx_src;
    logic [PW-1:0] rx_payload;
    logic          rx_overflow;
    logic          clr_stats;
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;
    logic [15:0]   drop_count;

    local_ni #(.NODE_ADDR(ME), .TX_DEPTH(4), .RX_DEPTH(8), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_dst        (tx_dst),
        .tx_payload    (tx_payload),
        .tx_err        (tx_err),
        .net_data_out  (net_data_out),
        .net_valid_out (net_valid_out),
        .net_full_in   (net_full_in),
        .net_data_in   (net_data_in),
        .net_valid_in  (net_valid_in),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_src        (rx_src),
        .rx_payload    (rx_payload),
        .rx_overflow   (rx_overflow),
        .clr_stats     (clr_stats),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_txq[$];
    logic [DW-1:0] m_rxq[$];
    int            m_tx_cnt;
    int            m_rx_cnt;
    int            m_drop_cnt;
    bit            m_ovf;
    bit            m_err;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Called 1 time unit after inputs are driven; compares every output.
    task automatic sample_check();
        logic [DW-1:0] head;
        #1;
        if (!rst) begin
            check("tx_ready", 64'(tx_ready), 64'(m_txq.size() < 4));
            check("tx_err", 64'(tx_err), 64'(m_err));
            check("valid_while_full", 64'(net_valid_out & net_full_in), 64'(0));
            check("tx_spurious", 64'(net_valid_out && (m_txq.size() == 0)), 64'(0));
            if (net_valid_out && m_txq.size() > 0) begin
                head = m_txq[0];
                check("tx_flit", 64'(net_data_out), 64'(head));
            end
            check("rx_valid", 64'(rx_valid), 64'(m_rxq.size() > 0));
            if (m_rxq.size() > 0) begin
                head = m_rxq[0];
                check("rx_src", 64'(rx_src), 64'(head[5:3]));
                check("rx_payload", 64'(rx_payload), 64'(head[DW-1:6]));
            end
            check("rx_overflow", 64'(rx_overflow), 64'(m_ovf));
            check("tx_count", 64'(tx_count), 64'(m_tx_cnt));
            check("rx_count", 64'(rx_count), 64'(m_rx_cnt));
            check("drop_count", 64'(drop_count), 64'(m_drop_cnt));
        end
    endtask

    // Applies this cycle's inputs to the model across the clock edge.
    task automatic advance();
        bit            was_rst, clr, t_push, t_err, t_pop, r_pop, r_push, r_drop;
        logic [DW-1:0] t_flit, r_flit;
        was_rst = rst;
        clr     = clr_stats;
        t_push  = tx_valid && (m_txq.size() < 4) && (tx_dst != ME);
        t_err   = tx_valid && (m_txq.size() < 4) && (tx_dst == ME);
        t_flit  = {tx_payload, ME, tx_dst};
        t_pop   = net_valid_out && (m_txq.size() > 0);
        r_pop   = rx_ready && (m_rxq.size() > 0);
        r_push  = 0;
        r_drop  = 0;
        r_flit  = net_data_in;
        if (net_valid_in) begin
            if (net_data_in[2:0] != ME)            r_drop = 1;
            else if (m_rxq.size() == 8 && !r_pop)  r_drop = 1;
            else                                   r_push = 1;
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            m_txq.delete();
            m_rxq.delete();
            m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0;
            m_ovf = 0; m_err = 0;
        end else begin
            if (t_pop)  void'(m_txq.pop_front());
            if (t_push) m_txq.push_back(t_flit);
            if (r_pop)  void'(m_rxq.pop_front());
            if (r_push) m_rxq.push_back(r_flit);
            m_err = t_err;
            if (clr) begin
                m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0; m_ovf = 0;
            end else begin
                if (t_pop)  m_tx_cnt   = sat(m_tx_cnt);
                if (r_push) m_rx_cnt   = sat(m_rx_cnt);
                if (r_drop) m_drop_cnt = sat(m_drop_cnt);
                if (r_drop) m_ovf = 1;
            end
        end
    endtask

    task automatic cyc();
        sample_check();
        advance();
    endtask

    task automatic drain_tx();
        tx_valid    = 0;
        net_full_in = 0;
        for (int k = 0; k < 40 && m_txq.size() > 0; k++) cyc();
        check("tx_drain_left", 64'(m_txq.size()), 64'(0));
    endtask

    function automatic logic [2:0] rand_not_me();
        logic [2:0] d;
        d = 3'($urandom_range(0, 7));
        return (d == ME) ? 3'd4 : d;
    endfunction

    function automatic logic [DW-1:0] rand_rx_flit(input logic [2:0] dst);
        logic [31:0] r;
        r = $urandom();
        return {r[31:6], r[5:3], dst};
    endfunction

    initial begin
        logic [31:0] r;
        int          t0;
        rst = 1; tx_valid = 0; tx_dst = 0; tx_payload = 0; net_full_in = 0;
        net_data_in = 0; net_valid_in = 0; rx_ready = 0; clr_stats = 0;
        m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0; m_ovf = 0; m_err = 0;

        // Reset
        cyc(); cyc();
        rst = 0;
        sample_check();
        check("rst_valid_out", 64'(net_valid_out), 64'(0));
        check("rst_tx_ready", 64'(tx_ready), 64'(1));
        check("rst_rx_valid", 64'(rx_valid), 64'(0));
        check("rst_counts", 64'({tx_count, rx_count, drop_count}), 64'(0));
        advance();

        // Injection latency: accept in N -> valid in N+1
        tx_valid = 1; tx_dst = 3'd5; tx_payload = 26'hAB;
        cyc();
        tx_valid = 0;
        sample_check();
        check("lat_valid", 64'(net_valid_out), 64'(1));
        check("lat_hdr", 64'(net_data_out[5:0]), 64'(6'b011101));
        check("lat_payload", 64'(net_data_out[DW-1:6]), 64'(26'hAB));
        advance();
        repeat (3) cyc();

        clr_stats = 1; cyc(); clr_stats = 0;

        // Four packets under full, then release
        net_full_in = 1;
        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            tx_valid = 1; tx_dst = 3'(i + 4); tx_payload = r[25:0];
            cyc();
        end
        tx_valid = 0;
        sample_check();
        check("full_ready_low", 64'(tx_ready), 64'(0));
        check("full_no_valid", 64'(net_valid_out), 64'(0));
        advance();
        net_full_in = 0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            sample_check();
            check("burst_valid", 64'(net_valid_out), 64'(1));
            advance();
        end
        sample_check();
        check("burst_tx_count", 64'(tx_count), 64'(4));
        check("burst_done", 64'(net_valid_out), 64'(0));
        advance();

        // net_full_in toggling every cycle during a stream
        for (int i = 0; i < 24; i++) begin
            r = $urandom();
            net_full_in = i[0];
            tx_valid = r[31]; tx_dst = rand_not_me(); tx_payload = r[25:0];
            cyc();
        end
        drain_tx();

        // Self-addressed packet
        t0 = m_tx_cnt;
        tx_valid = 1; tx_dst = ME; tx_payload = 26'h155;
        cyc();
        tx_valid = 0;
        sample_check();
        check("err_pulse", 64'(tx_err), 64'(1));
        check("err_no_inject", 64'(net_valid_out), 64'(0));
        advance();
        sample_check();
        check("err_one_cycle", 64'(tx_err), 64'(0));
        check("err_tx_count", 64'(tx_count), 64'(t0));
        advance();

        // RX overflow with rx_ready low
        clr_stats = 1; cyc(); clr_stats = 0;
        rx_ready = 0; net_valid_in = 1;
        for (int i = 0; i < 10; i++) begin
            net_data_in = rand_rx_flit(ME);
            cyc();
        end
        net_valid_in = 0;
        sample_check();
        check("rx_buffered", 64'(rx_count), 64'(8));
        check("rx_drop2", 64'(drop_count), 64'(2));
        check("rx_ovf_set", 64'(rx_overflow), 64'(1));
        advance();
        net_valid_in = 1; net_data_in = rand_rx_flit(3'd6);
        cyc();
        net_valid_in = 0;
        sample_check();
        check("rx_misroute_drop", 64'(drop_count), 64'(3));
        advance();
        // push + pop on a full RX FIFO is not a drop
        net_valid_in = 1; net_data_in = rand_rx_flit(ME); rx_ready = 1;
        cyc();
        net_valid_in = 0; rx_ready = 0;
        sample_check();
        check("rx_fullpp_drop", 64'(drop_count), 64'(3));
        check("rx_fullpp_count", 64'(rx_count), 64'(9));
        advance();
        rx_ready = 1;
        repeat (10) cyc();
        rx_ready = 0;
        clr_stats = 1; cyc(); clr_stats = 0;
        sample_check();
        check("clr_ovf", 64'(rx_overflow), 64'(0));
        check("clr_drop", 64'(drop_count), 64'(0));
        advance();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom();
            tx_valid     = ($urandom_range(0, 99) < 60);
            tx_dst       = 3'($urandom_range(0, 7));
            tx_payload   = r[25:0];
            net_full_in  = ($urandom_range(0, 99) < 30);
            net_valid_in = ($urandom_range(0, 99) < 50);
            net_data_in  = rand_rx_flit(($urandom_range(0, 99) < 80) ? ME : 3'($urandom_range(0, 7)));
            rx_ready     = ($urandom_range(0, 99) < 40);
            clr_stats    = ($urandom_range(0, 99) < 2);
            cyc();
        end
        net_valid_in = 0; rx_ready = 0; clr_stats = 0;
        drain_tx();

        // Reset while stalled with 3 queued packets
        net_full_in = 1;
        for (int i = 0; i < 3; i++) begin
            r = $urandom();
            tx_valid = 1; tx_dst = 3'd1; tx_payload = r[25:0];
            cyc();
        end
        tx_valid = 0;
        net_valid_in = 1; net_data_in = rand_rx_flit(ME);
        cyc();
        net_valid_in = 0;
        rst = 1;
        cyc();
        rst = 0; net_full_in = 0;
        sample_check();
        check("rst2_valid", 64'(net_valid_out), 64'(0));
        check("rst2_ready", 64'(tx_ready), 64'(1));
        check("rst2_rx_valid", 64'(rx_valid), 64'(0));
        check("rst2_counts", 64'({tx_count, rx_count, drop_count}), 64'(0));
        advance();
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
